// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered ALU between fetch (req0) and execute (req1).
// Operands are issued from registers; the result is captured after ALU_LAT edges and tagged with its owner.
module alu_arbiter #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned ALU_LAT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [3:0]       req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [3:0]       req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic [3:0]       alu_cntrl,
   output logic [WIDTH-1:0] data_1,
   output logic [WIDTH-1:0] data_2,
   input  logic [WIDTH-1:0] alu_out,
   output logic             rsp_valid,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_zero,
   output logic             rsp_err,
   output logic             busy
);

   localparam int unsigned CW = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t           state;
   logic             ptr;
   logic [CW-1:0]    cnt;
   logic             id;
   logic             grant0, grant1;
   logic [3:0]       acc_op;
   logic [WIDTH-1:0] acc_a, acc_b;
   logic             op_legal;

   // ptr=0 favours req0 on a tie; a lone requester wins regardless of ptr.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (rst_n && state == IDLE) begin
         if (req0_valid && req1_valid) begin
            grant0 = ~ptr;
            grant1 = ptr;
         end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
         end
      end
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign acc_op     = grant1 ? req1_op : req0_op;
   assign acc_a      = grant1 ? req1_a  : req0_a;
   assign acc_b      = grant1 ? req1_b  : req0_b;
   assign op_legal   = (acc_op <= 4'd4);
   assign busy       = (state != IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         ptr        <= 1'b0;
         cnt        <= '0;
         id         <= 1'b0;
         alu_cntrl  <= '0;
         data_1     <= '0;
         data_2     <= '0;
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_result <= '0;
         rsp_zero   <= 1'b0;
         rsp_err    <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (grant0 || grant1) begin
                  ptr <= grant0;
                  if (op_legal) begin
                     alu_cntrl <= acc_op;
                     data_1    <= acc_a;
                     data_2    <= acc_b;
                     id        <= grant1;
                     cnt       <= CW'(ALU_LAT);
                     state     <= EXEC;
                  end else begin
                     // Illegal opcode never reaches the ALU; answer immediately.
                     rsp_id     <= grant1;
                     rsp_result <= '0;
                     rsp_zero   <= 1'b0;
                     rsp_err    <= 1'b1;
                     rsp_valid  <= 1'b1;
                     state      <= RESP;
                  end
               end
            end
            EXEC: begin
               if (cnt != '0) begin
                  cnt <= cnt - CW'(1);
               end else begin
                  rsp_id     <= id;
                  rsp_result <= alu_out;
                  rsp_zero   <= (alu_out == '0);
                  rsp_err    <= 1'b0;
                  rsp_valid  <= 1'b1;
                  state      <= RESP;
               end
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU plus a transaction-level scoreboard checked every cycle.
module tb_alu_arbiter;

   localparam int W   = 32;
   localparam int LAT = 1;

   typedef struct packed {
      logic [3:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
   } op_t;

   typedef struct packed {
      logic         id;
      logic [W-1:0] res;
      logic         zero;
      logic         err;
   } rsp_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         req0_valid = 1'b0, req1_valid = 1'b0;
   logic         req0_ready, req1_ready;
   logic [3:0]   req0_op = '0, req1_op = '0;
   logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic [3:0]   alu_cntrl;
   logic [W-1:0] data_1, data_2, alu_out;
   logic         rsp_valid, rsp_id, rsp_zero, rsp_err, busy;
   logic [W-1:0] rsp_result;
   logic [W-1:0] pipe [LAT];

   int   n_cmp = 0;
   int   n_bad = 0;
   logic hs0 = 1'b0, hs1 = 1'b0;
   op_t  q0[$], q1[$];
   rsp_t rsp_log[$];

   always #5 clk = ~clk;

   alu_arbiter #(.WIDTH(W), .ALU_LAT(LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
      .alu_cntrl(alu_cntrl), .data_1(data_1), .data_2(data_2), .alu_out(alu_out),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_zero(rsp_zero),
      .rsp_err(rsp_err), .busy(busy)
   );

   function automatic logic [W-1:0] alu_f(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      case (op)
         4'd0:    return a & b;
         4'd1:    return a | b;
         4'd2:    return a + b;
         4'd3:    return a - b;
         4'd4:    return a * b;
         default: return '0;
      endcase
   endfunction

   // Registered ALU: output valid LAT edges after its inputs settle.
   always_ff @(posedge clk) begin
      pipe[0] <= alu_f(alu_cntrl, data_1, data_2);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign alu_out = pipe[LAT-1];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Scoreboard: tracks when the block is free, the tie pointer, issued operands and the pending response.
   initial begin : scoreboard
      int           cyc;
      int           m_free, m_rsp_cyc;
      logic         m_ptr, g0, g1;
      logic [3:0]   m_cntrl, op;
      logic [W-1:0] m_d1, m_d2, a, b;
      rsp_t         held, pend;
      cyc = 0; m_free = 0; m_rsp_cyc = -1; m_ptr = 1'b0;
      m_cntrl = '0; m_d1 = '0; m_d2 = '0; held = '0; pend = '0;
      forever begin
         @(negedge clk);
         cyc++;
         hs0 = 1'b0;
         hs1 = 1'b0;
         if (!rst_n) begin
            check_eq("ready0_in_reset", req0_ready, 0);
            check_eq("ready1_in_reset", req1_ready, 0);
            m_ptr = 1'b0; m_free = cyc + 1; m_rsp_cyc = -1;
            m_cntrl = '0; m_d1 = '0; m_d2 = '0; held = '0;
         end else begin
            if (cyc == m_rsp_cyc) held = pend;
            check_eq("rsp_valid", rsp_valid, (cyc == m_rsp_cyc));
            check_eq("busy", busy, (cyc < m_free));
            g0 = 1'b0; g1 = 1'b0;
            if (cyc >= m_free) begin
               if (req0_valid && req1_valid) begin
                  g0 = ~m_ptr; g1 = m_ptr;
               end else begin
                  g0 = req0_valid; g1 = req1_valid;
               end
            end
            check_eq("req0_ready", req0_ready, g0);
            check_eq("req1_ready", req1_ready, g1);
            check_eq("alu_cntrl", alu_cntrl, m_cntrl);
            check_eq("data_1", data_1, m_d1);
            check_eq("data_2", data_2, m_d2);
            check_eq("rsp_id", rsp_id, held.id);
            check_eq("rsp_result", rsp_result, held.res);
            check_eq("rsp_zero", rsp_zero, held.zero);
            check_eq("rsp_err", rsp_err, held.err);
            if (rsp_valid) rsp_log.push_back('{rsp_id, rsp_result, rsp_zero, rsp_err});
            if (g0 || g1) begin
               hs0 = g0; hs1 = g1;
               op = g1 ? req1_op : req0_op;
               a  = g1 ? req1_a  : req0_a;
               b  = g1 ? req1_b  : req0_b;
               pend.id = g1;
               if (op <= 4'd4) begin
                  m_cntrl = op; m_d1 = a; m_d2 = b;
                  pend.res  = alu_f(op, a, b);
                  pend.zero = (pend.res == '0);
                  pend.err  = 1'b0;
                  m_rsp_cyc = cyc + LAT + 2;
                  m_free    = cyc + LAT + 3;
               end else begin
                  pend.res = '0; pend.zero = 1'b0; pend.err = 1'b1;
                  m_rsp_cyc = cyc + 1;
                  m_free    = cyc + 2;
               end
               m_ptr = g0;
            end
         end
      end
   end

   function automatic logic [W-1:0] rand_val();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return '1;
         2:       return W'(32'h0001_0000);
         default: return W'($urandom);
      endcase
   endfunction

   function automatic op_t rand_op();
      op_t t;
      t.op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(5, 15)) : 4'($urandom_range(0, 4));
      t.a  = rand_val();
      t.b  = ($urandom_range(0, 7) == 0) ? t.a : rand_val();
      return t;
   endfunction

   task automatic set_req(input int r, input logic v, input op_t t);
      if (r == 0) begin
         req0_valid = v; req0_op = t.op; req0_a = t.a; req0_b = t.b;
      end else begin
         req1_valid = v; req1_op = t.op; req1_a = t.a; req1_b = t.b;
      end
   endtask

   // Feed queued ops; a requester holds its op until its handshake, then loads the next one.
   task automatic run_queues();
      int unsigned guard;
      op_t t;
      guard = 0;
      while ((q0.size() != 0 || q1.size() != 0 || req0_valid || req1_valid) && guard < 200) begin
         @(posedge clk); #1;
         guard++;
         if (hs0 || !req0_valid) begin
            if (q0.size() != 0) begin t = q0.pop_front(); set_req(0, 1'b1, t); end
            else req0_valid = 1'b0;
         end
         if (hs1 || !req1_valid) begin
            if (q1.size() != 0) begin t = q1.pop_front(); set_req(1, 1'b1, t); end
            else req1_valid = 1'b0;
         end
      end
      check_eq("queues_drained", (q0.size() == 0 && q1.size() == 0 && !req0_valid && !req1_valid), 1);
      repeat (LAT + 4) @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      @(posedge clk); #1 rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
   endtask

   initial begin : stimulus
      int unsigned g;
      int          n0;
      op_t         t;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check_eq("reset_busy", busy, 0);
      check_eq("reset_rsp_valid", rsp_valid, 0);
      check_eq("reset_data_1", data_1, 0);
      check_eq("reset_alu_cntrl", alu_cntrl, 0);

      rsp_log.delete();
      q0.push_back('{4'd2, W'(5), W'(7)});
      run_queues();
      check_eq("t1_count", rsp_log.size(), 1);
      if (rsp_log.size() >= 1) begin
         check_eq("t1_id", rsp_log[0].id, 0);
         check_eq("t1_res", rsp_log[0].res, 12);
         check_eq("t1_zero", rsp_log[0].zero, 0);
         check_eq("t1_err", rsp_log[0].err, 0);
      end

      pulse_reset();
      rsp_log.delete();
      q0.push_back('{4'd3, W'(9), W'(9)});
      q1.push_back('{4'd1, W'(32'hF0), W'(32'h0F)});
      run_queues();
      check_eq("t2_count", rsp_log.size(), 2);
      if (rsp_log.size() >= 2) begin
         check_eq("t2_first_id", rsp_log[0].id, 0);
         check_eq("t2_first_res", rsp_log[0].res, 0);
         check_eq("t2_first_zero", rsp_log[0].zero, 1);
         check_eq("t2_second_id", rsp_log[1].id, 1);
         check_eq("t2_second_res", rsp_log[1].res, 32'hFF);
      end

      rsp_log.delete();
      for (int i = 0; i < 3; i++) begin
         q0.push_back('{4'd2, W'(i), W'(100)});
         q1.push_back('{4'd0, W'(32'hFFFF), W'(i + 1)});
      end
      run_queues();
      check_eq("t3_count", rsp_log.size(), 6);
      for (int i = 0; i < 6 && i < rsp_log.size(); i++)
         check_eq($sformatf("t3_alt%0d", i), rsp_log[i].id, i % 2);

      rsp_log.delete();
      q1.push_back('{4'b0111, W'(32'h1234), W'(32'h5678)});
      run_queues();
      check_eq("t4_count", rsp_log.size(), 1);
      if (rsp_log.size() >= 1) begin
         check_eq("t4_id", rsp_log[0].id, 1);
         check_eq("t4_err", rsp_log[0].err, 1);
         check_eq("t4_res", rsp_log[0].res, 0);
      end

      rsp_log.delete();
      q0.push_back('{4'd4, W'(32'h10000), W'(32'h10000)});
      q1.push_back('{4'd2, W'(32'hFFFF_FFFF), W'(1)});
      run_queues();
      check_eq("t5_count", rsp_log.size(), 2);
      for (int i = 0; i < 2 && i < rsp_log.size(); i++) begin
         check_eq($sformatf("t5_res%0d", i), rsp_log[i].res, 0);
         check_eq($sformatf("t5_zero%0d", i), rsp_log[i].zero, 1);
      end

      // Reset lands in the cycle after the handshake, while the op is in flight.
      n0 = rsp_log.size();
      @(posedge clk); #1;
      set_req(0, 1'b1, '{4'd2, W'(3), W'(4)});
      g = 0;
      do begin @(posedge clk); #1; g++; end while (!hs0 && g < 20);
      check_eq("t6_handshake", hs0, 1);
      req0_valid = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      check_eq("t6_busy", busy, 0);
      check_eq("t6_data_1", data_1, 0);
      check_eq("t6_rsp_valid", rsp_valid, 0);
      repeat (6) @(posedge clk);
      check_eq("t6_dropped", rsp_log.size(), n0);
      rsp_log.delete();
      q1.push_back('{4'd2, W'(20), W'(22)});
      run_queues();
      check_eq("t6_fresh_count", rsp_log.size(), 1);
      if (rsp_log.size() >= 1) begin
         check_eq("t6_fresh_id", rsp_log[0].id, 1);
         check_eq("t6_fresh_res", rsp_log[0].res, 42);
      end

      // Random traffic: new ops after handshakes, occasional withdrawals and resets.
      for (int k = 0; k < 3000; k++) begin
         @(posedge clk); #1;
         rst_n = ($urandom_range(0, 299) != 0);
         if (hs0 || !req0_valid) begin
            t = rand_op();
            set_req(0, ($urandom_range(0, 2) != 0), t);
         end else if ($urandom_range(0, 15) == 0) req0_valid = 1'b0;
         if (hs1 || !req1_valid) begin
            t = rand_op();
            set_req(1, ($urandom_range(0, 2) != 0), t);
         end else if ($urandom_range(0, 15) == 0) req1_valid = 1'b0;
      end
      rst_n = 1'b1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      repeat (LAT + 5) @(posedge clk);
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
